// File: rtl/drum_motor_controller.sv
// ----------------------------------------------------------------------------
// drum_motor_controller
//
// Purpose:
//   Sequences the drum motor on behalf of the wash FSM. The block ramps the
//   commanded speed toward a goal, runs the wash tumble pattern
//   (on / brake / dwell / reverse) or a continuous final spin, backs the
//   goal off when the drum vibrates, and declares a vibration fault once the
//   allowed back-offs are used up. Every speed change happens on a prescaled
//   ramp tick, so the drive never sees a step larger than RAMP_STEP.
//
// Ports:
//   clk              in   1   system clock
//   reset            in   1   synchronous, active-high reset
//   enable           in   1   run request from the wash FSM (level)
//   stop             in   1   cancel request, dominates enable
//   spin_mode        in   1   0 = tumble, 1 = continuous spin (latched on start)
//   target_speed     in   11  requested rpm
//   vibration_sensor in   1   drum imbalance detected (level)
//   motor_speed      out  11  commanded rpm to the drive
//   motor_dir        out  1   drum direction
//   at_speed         out  1   holding at the goal speed
//   motor_idle       out  1   block is idle
//   vibration_fault  out  1   vibration retries exhausted
// ----------------------------------------------------------------------------
module drum_motor_controller #(
    parameter logic [15:0] TICK_DIV    = 16'd1000,
    parameter logic [10:0] RAMP_STEP   = 11'd8,
    parameter logic [10:0] MAX_SPEED   = 11'd1400,
    parameter logic [7:0]  TUMBLE_ON   = 8'd12,
    parameter logic [7:0]  TUMBLE_OFF  = 8'd3,
    parameter logic [10:0] VIB_BACKOFF = 11'd200,
    parameter logic [1:0]  MAX_RETRY   = 2'd2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    input  logic        stop,
    input  logic        spin_mode,
    input  logic [10:0] target_speed,
    input  logic        vibration_sensor,
    output logic [10:0] motor_speed,
    output logic        motor_dir,
    output logic        at_speed,
    output logic        motor_idle,
    output logic        vibration_fault
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RAMP,
        ST_HOLD,
        ST_BRAKE,
        ST_DWELL,
        ST_FAULT
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] tick_cnt_q, tick_cnt_d;
    logic [10:0] speed_q, speed_d;
    logic        dir_q, dir_d;
    logic        spin_q, spin_d;
    logic [1:0]  retry_q, retry_d;
    logic [10:0] backoff_q, backoff_d;
    logic [7:0]  phase_q, phase_d;
    logic        fault_q, fault_d;

    logic        tick;
    logic        halt;
    logic [10:0] clamped;
    logic [10:0] goal;
    logic [11:0] up_sum;
    logic [10:0] ramp_next;
    logic [10:0] brake_next;
    logic [11:0] backoff_sum;
    logic [10:0] backoff_sat;

    // Goal, single ramp step and brake step. All arithmetic is done so the
    // result never overshoots the goal and never wraps below zero.
    always_comb begin
        clamped     = (target_speed > MAX_SPEED) ? MAX_SPEED : target_speed;
        goal        = (clamped > backoff_q) ? (clamped - backoff_q) : 11'd0;
        up_sum      = {1'b0, speed_q} + {1'b0, RAMP_STEP};
        ramp_next   = speed_q;
        if (speed_q < goal) begin
            ramp_next = (up_sum > {1'b0, goal}) ? goal : up_sum[10:0];
        end else if (speed_q > goal) begin
            ramp_next = ((speed_q - goal) > RAMP_STEP) ? (speed_q - RAMP_STEP) : goal;
        end
        brake_next  = (speed_q > RAMP_STEP) ? (speed_q - RAMP_STEP) : 11'd0;
        backoff_sum = {1'b0, backoff_q} + {1'b0, VIB_BACKOFF};
        backoff_sat = backoff_sum[11] ? 11'h7FF : backoff_sum[10:0];
        tick        = (state_q != ST_IDLE) && (tick_cnt_q == (TICK_DIV - 16'd1));
        halt        = stop || !enable;
    end

    // Next-state logic. Stop/!enable win over vibration, which wins over the
    // normal sequencing; speed and counters only move on the ramp tick.
    always_comb begin
        state_d    = state_q;
        tick_cnt_d = (state_q == ST_IDLE || tick) ? 16'd0 : (tick_cnt_q + 16'd1);
        speed_d    = speed_q;
        dir_d      = dir_q;
        spin_d     = spin_q;
        retry_d    = retry_q;
        backoff_d  = backoff_q;
        phase_d    = phase_q;
        fault_d    = fault_q;

        case (state_q)
            ST_IDLE: begin
                if (enable && !stop) begin
                    state_d    = ST_RAMP;
                    tick_cnt_d = 16'd0;
                    spin_d     = spin_mode;
                    retry_d    = 2'd0;
                    backoff_d  = 11'd0;
                    dir_d      = 1'b0;
                    fault_d    = 1'b0;
                end
            end

            ST_RAMP: begin
                if (halt) begin
                    state_d = ST_BRAKE;
                end else if (tick) begin
                    // The step uses the goal as it stood before any back-off
                    // taken on this same tick.
                    speed_d = ramp_next;
                    if (vibration_sensor) begin
                        if (retry_q < MAX_RETRY) begin
                            backoff_d = backoff_sat;
                            retry_d   = retry_q + 2'd1;
                        end else begin
                            state_d = ST_FAULT;
                            fault_d = 1'b1;
                        end
                    end else if (ramp_next == goal) begin
                        state_d = ST_HOLD;
                    end
                end
            end

            ST_HOLD: begin
                if (halt) begin
                    state_d = ST_BRAKE;
                end else if (tick) begin
                    if (vibration_sensor) begin
                        if (retry_q < MAX_RETRY) begin
                            backoff_d = backoff_sat;
                            retry_d   = retry_q + 2'd1;
                            state_d   = ST_RAMP;
                        end else begin
                            state_d = ST_FAULT;
                            fault_d = 1'b1;
                        end
                    end else if (spin_q) begin
                        if (goal != speed_q) begin
                            state_d = ST_RAMP;
                        end
                    end else if ((phase_q + 8'd1) >= TUMBLE_ON) begin
                        state_d = ST_BRAKE;
                    end else begin
                        phase_d = phase_q + 8'd1;
                    end
                end
            end

            ST_BRAKE: begin
                if (tick) begin
                    speed_d = brake_next;
                    if (brake_next == 11'd0) begin
                        if (halt) begin
                            state_d = ST_IDLE;
                        end else if (spin_q) begin
                            state_d = ST_RAMP;
                        end else begin
                            state_d = ST_DWELL;
                        end
                    end
                end
            end

            ST_DWELL: begin
                if (halt) begin
                    state_d = ST_IDLE;
                end else if (tick) begin
                    if ((phase_q + 8'd1) >= TUMBLE_OFF) begin
                        dir_d   = !dir_q;
                        state_d = ST_RAMP;
                    end else begin
                        phase_d = phase_q + 8'd1;
                    end
                end
            end

            ST_FAULT: begin
                fault_d = 1'b1;
                if (speed_q == 11'd0 && !enable) begin
                    state_d = ST_IDLE;
                end else if (tick) begin
                    speed_d = brake_next;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Tumble phase counting restarts on every state change.
        if (state_d != state_q) begin
            phase_d = 8'd0;
        end
    end

    // State register with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            tick_cnt_q <= 16'd0;
            speed_q    <= 11'd0;
            dir_q      <= 1'b0;
            spin_q     <= 1'b0;
            retry_q    <= 2'd0;
            backoff_q  <= 11'd0;
            phase_q    <= 8'd0;
            fault_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            tick_cnt_q <= tick_cnt_d;
            speed_q    <= speed_d;
            dir_q      <= dir_d;
            spin_q     <= spin_d;
            retry_q    <= retry_d;
            backoff_q  <= backoff_d;
            phase_q    <= phase_d;
            fault_q    <= fault_d;
        end
    end

    assign motor_speed     = speed_q;
    assign motor_dir       = dir_q;
    assign at_speed        = (state_q == ST_HOLD) && (speed_q == goal);
    assign motor_idle      = (state_q == ST_IDLE);
    assign vibration_fault = fault_q;

endmodule
